// File: rtl/dg0045_pkg.sv
// dg0045_pkg: phase constants, fetch FSM states and the PL polynomial successor shared by core, fetch stage and ROM model
package dg0045_pkg;
  localparam int PH_FETCH = 0;
  localparam int PH_CHECK = 3;
  localparam int PH_LO_SAMPLE = 6;
  localparam int PH_HI_SAMPLE = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_LATE} fetch_st_e;
  function automatic logic [5:0] pl_next(input logic [5:0] pl);
    return {pl[0] ~^ pl[1], pl[5:1]};
  endfunction
endpackage

// File: rtl/dg0045_rom_fetch.sv
// dg0045_rom_fetch: rebuilds the core PC from PC_HL/PC_MUX, prefetches the predicted next byte from ROM
// and holds it on ui_in across the core's phase-4 latch edge.
module dg0045_rom_fetch
  import dg0045_pkg::*;
#(
  parameter int DEADLINE_PHASE = 3,
  parameter logic [7:0] NOP_BYTE = 8'h00,
  parameter int LATE_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [4:0] pc_hl,
  output logic pc_mux,
  output logic rom_req,
  output logic [9:0] rom_addr,
  input  logic rom_ack,
  input  logic [7:0] rom_data,
  output logic [7:0] instr_out,
  output logic fetch_late,
  output logic pred_miss,
  output logic [LATE_CNT_W-1:0] late_count
);
  logic [2:0] phase_q, phase_d;
  fetch_st_e st_q, st_d;
  logic [4:0] lo_q, lo_d;
  logic [9:0] addr_q, addr_d;
  logic [7:0] instr_q, instr_d;
  logic late_q, late_d, miss_q, miss_d;
  logic [LATE_CNT_W-1:0] cnt_q, cnt_d;
  logic ack_ok, deadline;
  always_comb begin
    phase_d = phase_q + 3'd1;
    ack_ok = st_q == ST_WAIT && rom_ack;
    deadline = st_q == ST_WAIT && !rom_ack && phase_q == 3'(DEADLINE_PHASE - 1);
    st_d = st_q;
    addr_d = addr_q;
    instr_d = instr_q;
    late_d = late_q;
    cnt_d = cnt_q;
    lo_d = phase_q == 3'(PH_LO_SAMPLE) ? pc_hl : lo_q;
    miss_d = miss_q | (phase_q == 3'(PH_CHECK) && pc_hl != addr_q[4:0]);
    if (ack_ok) begin
      st_d = ST_DONE;
      instr_d = rom_data;
    end else if (deadline) begin
      st_d = ST_LATE;
      late_d = 1'b1;
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
    if (phase_d == 3'(PH_HI_SAMPLE) && st_q != ST_WAIT) st_d = ST_IDLE;
    // The high half is on pc_hl during this very cycle, so it feeds the address directly
    if (phase_d == 3'(PH_FETCH)) begin
      st_d = ST_WAIT;
      addr_d = {pc_hl[4:1], pl_next({pc_hl[0], lo_q})};
      instr_d = NOP_BYTE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 3'(PH_FETCH);
      st_q <= ST_WAIT;
      lo_q <= '0;
      addr_q <= {4'h0, pl_next(6'h00)};
      instr_q <= 8'h00;
      late_q <= 1'b0;
      miss_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      phase_q <= phase_d;
      st_q <= st_d;
      lo_q <= lo_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      late_q <= late_d;
      miss_q <= miss_d;
      cnt_q <= cnt_d;
    end
  end
  // Reset starts in WAIT on the PC=0 successor, so the first phase 0 after release already requests 0x020
  assign pc_mux = phase_q == 3'(PH_HI_SAMPLE);
  assign rom_req = rst_n && st_q == ST_WAIT;
  assign rom_addr = rst_n ? addr_q : '0;
  assign instr_out = instr_q;
  assign fetch_late = late_q;
  assign pred_miss = miss_q;
  assign late_count = cnt_q;
endmodule

// File: tb/tb_dg0045_rom_fetch.sv
// tb_dg0045_rom_fetch: frame-by-frame directed stimulus with a scoreboard checked in phase 4 of each frame.
module tb_dg0045_rom_fetch;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] pc_hl;
  logic pc_mux, rom_req, rom_ack, fetch_late, pred_miss;
  logic [9:0] rom_addr;
  logic [7:0] rom_data, instr_out, late_count;
  logic [2:0] ph = 3'd0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] instr;
    logic late;
    logic [7:0] cnt;
    logic miss;
  } exp_t;
  exp_t sb[$];

  logic [9:0] f_addr[6] = '{10'h020, 10'h280, 10'h3FF, 10'h160, 10'h160, 10'h020};
  int f_ack[6] = '{0, 2, 3, 1, 0, 8};
  logic [9:0] f_pc[6] = '{10'h281, 10'h3FF, 10'h140, 10'h140, 10'h000, 10'h281};
  logic [4:0] f_lo3[6] = '{5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00};
  logic [7:0] f_instr[6] = '{8'h3C, 8'hA5, 8'h00, 8'hC3, 8'hC3, 8'h00};
  logic f_late[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] f_cnt[6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
  logic f_miss[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  dg0045_rom_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_hl(pc_hl), .pc_mux(pc_mux), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data), .instr_out(instr_out),
    .fetch_late(fetch_late), .pred_miss(pred_miss), .late_count(late_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ph <= rst_n ? ph + 3'd1 : 3'd0;

  function automatic logic [7:0] rom_model(input logic [9:0] a);
    case (a)
      10'h020: return 8'h3C;
      10'h280: return 8'hA5;
      10'h3FF: return 8'h5A;
      10'h160: return 8'hC3;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ph == 3'd4 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(e.addr));
      chk("instr_out", 32'(instr_out), 32'(e.instr));
      chk("fetch_late", 32'(fetch_late), 32'(e.late));
      chk("late_count", 32'(late_count), 32'(e.cnt));
      chk("pred_miss", 32'(pred_miss), 32'(e.miss));
      chk("req_idle_ph4", 32'(rom_req), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    rom_ack = 1'b0;
    rom_data = 8'h00;
    pc_hl = 5'h00;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_late", 32'(fetch_late), 32'd0);
    chk("rst_cnt", 32'(late_count), 32'd0);
    chk("rst_miss", 32'(pred_miss), 32'd0);
    chk("rst_pc_mux", 32'(pc_mux), 32'd0);
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        if (f == 0 && p == 0) rst_n = 1'b1;
        if (p == 0) begin
          #1;
          chk("fetch_req", 32'(rom_req), 32'd1);
          sb.push_back('{addr: f_addr[f], instr: f_instr[f], late: f_late[f], cnt: f_cnt[f], miss: f_miss[f]});
        end
        rom_ack = p == f_ack[f];
        rom_data = rom_model(rom_addr);
        pc_hl = p == 6 ? f_pc[f][4:0] : p == 7 ? f_pc[f][9:5] : p == 3 ? f_lo3[f] : 5'h00;
        if (p == 6) chk("pc_mux_ph6", 32'(pc_mux), 32'd0);
        if (p == 7) chk("pc_mux_ph7", 32'(pc_mux), 32'd1);
      end
    end
    @(negedge clk);
    rom_ack = 1'b0;
    pc_hl = 5'h00;
    #1 chk("f6_addr", 32'(rom_addr), 32'h280);
    @(negedge clk);
    rst_n = 1'b0;
    rom_ack = 1'b1;
    rom_data = 8'hEE;
    #1 chk("rst_abort_req", 32'(rom_req), 32'd0);
    @(negedge clk);
    chk("rst2_instr", 32'(instr_out), 32'd0);
    chk("rst2_late", 32'(fetch_late), 32'd0);
    chk("rst2_cnt", 32'(late_count), 32'd0);
    chk("rst2_miss", 32'(pred_miss), 32'd0);
    rom_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req", 32'(rom_req), 32'd1);
    chk("rel_addr", 32'(rom_addr), 32'h020);
    repeat (7) @(negedge clk);
    chk("rel_pc_mux_ph7", 32'(pc_mux), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
